// File: rtl/osd_mam_burst_splitter.sv
// Splits upstream memory requests into downstream bursts of at most MAX_BURST beats that never cross a BOUNDARY-byte line.
// Data beats pass straight through combinationally; one sub-request is outstanding at a time.
module osd_mam_burst_splitter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BURST  = 16,
  parameter int BOUNDARY   = 4096
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_rw,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic                    req_burst,
  input  logic [13:0]             req_beats,

  input  logic                    write_valid,
  input  logic [DATA_WIDTH-1:0]   write_data,
  input  logic [DATA_WIDTH/8-1:0] write_strb,
  output logic                    write_ready,

  output logic                    read_valid,
  output logic [DATA_WIDTH-1:0]   read_data,
  input  logic                    read_ready,

  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_req_rw,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  output logic                    mem_req_burst,
  output logic [13:0]             mem_req_beats,

  output logic                    mem_write_valid,
  output logic [DATA_WIDTH-1:0]   mem_write_data,
  output logic [DATA_WIDTH/8-1:0] mem_write_strb,
  input  logic                    mem_write_ready,

  input  logic                    mem_read_valid,
  input  logic [DATA_WIDTH-1:0]   mem_read_data,
  output logic                    mem_read_ready,

  output logic                    busy
);

  localparam int BPB = DATA_WIDTH / 8;
  localparam int OFF = $clog2(BPB);
  localparam int BW  = $clog2(BOUNDARY);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BPB - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DATA} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [13:0]             remaining_q;
  logic [13:0]             chunk_q;
  logic [13:0]             beat_cnt_q;
  logic                    rw_q;
  logic                    burst_q;

  logic [ADDR_WIDTH-1:0]   load_addr;
  logic [13:0]             load_rem;
  logic [ADDR_WIDTH-1:0]   addr_adv;
  logic [13:0]             rem_left;
  logic                    beat_hs;
  logic                    last_beat;

  // Beats available before the boundary, given the beat index within the boundary window.
  function automatic logic [13:0] chunk_of(input logic [BW-OFF-1:0] idx, input logic [13:0] rem);
    logic [31:0] room;
    logic [31:0] c;
    room = 32'(BOUNDARY >> OFF) - 32'(idx);
    c    = 32'(rem);
    if (c > 32'(MAX_BURST)) c = 32'(MAX_BURST);
    if (c > room)           c = room;
    return 14'(c);
  endfunction

  // Single transfers keep their byte address; bursts are beat-aligned.
  assign load_addr = req_burst ? (req_addr & ALIGN_MASK) : req_addr;
  assign load_rem  = req_burst ? req_beats : 14'd1;
  assign addr_adv  = addr_q + (ADDR_WIDTH'(chunk_q) << OFF);
  assign rem_left  = remaining_q - chunk_q;

  assign beat_hs   = (state == DATA) &&
                     (rw_q ? (write_valid && mem_write_ready) : (mem_read_valid && read_ready));
  assign last_beat = beat_hs && (beat_cnt_q == 14'd1);

  assign mem_req_rw     = rw_q;
  assign mem_req_addr   = addr_q;
  assign mem_req_burst  = burst_q;
  assign mem_req_beats  = chunk_q;
  assign mem_write_data = write_data;
  assign mem_write_strb = write_strb;
  assign read_data      = mem_read_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    req_ready       = 1'b0;
    mem_req_valid   = 1'b0;
    busy            = 1'b0;
    mem_write_valid = 1'b0;
    write_ready     = 1'b0;
    read_valid      = 1'b0;
    mem_read_ready  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = rst_n;
        // A zero-length burst is consumed here without leaving IDLE.
        if (rst_n && req_valid && !(req_burst && req_beats == 14'd0))
          state_nxt = ISSUE;
      end
      ISSUE: begin
        busy          = 1'b1;
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_nxt = DATA;
      end
      DATA: begin
        busy = 1'b1;
        if (rw_q) begin
          mem_write_valid = write_valid;
          write_ready     = mem_write_ready;
        end else begin
          read_valid      = mem_read_valid;
          mem_read_ready  = read_ready;
        end
        if (last_beat) state_nxt = (rem_left == 14'd0) ? IDLE : ISSUE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      remaining_q <= '0;
      chunk_q     <= '0;
      beat_cnt_q  <= '0;
      rw_q        <= 1'b0;
      burst_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            rw_q        <= req_rw;
            burst_q     <= req_burst;
            addr_q      <= load_addr;
            remaining_q <= load_rem;
            chunk_q     <= chunk_of(load_addr[BW-1:OFF], load_rem);
          end
        end
        ISSUE: begin
          if (mem_req_ready) beat_cnt_q <= chunk_q;
        end
        DATA: begin
          if (beat_hs) beat_cnt_q <= beat_cnt_q - 14'd1;
          if (last_beat) begin
            addr_q      <= addr_adv;
            remaining_q <= rem_left;
            chunk_q     <= chunk_of(addr_adv[BW-1:OFF], rem_left);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_osd_mam_burst_splitter.sv
// Directed bench for osd_mam_burst_splitter at DATA_WIDTH=32: table of split requests plus stall and reset sequences.
module tb_osd_mam_burst_splitter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_rw, req_burst;
  logic [31:0] req_addr;
  logic [13:0] req_beats;
  logic        write_valid, write_ready;
  logic [31:0] write_data;
  logic [3:0]  write_strb;
  logic        read_valid, read_ready;
  logic [31:0] read_data;
  logic        mem_req_valid, mem_req_ready, mem_req_rw, mem_req_burst;
  logic [31:0] mem_req_addr;
  logic [13:0] mem_req_beats;
  logic        mem_write_valid, mem_write_ready;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_write_strb;
  logic        mem_read_valid, mem_read_ready;
  logic [31:0] mem_read_data;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int beat_seq = 0;

  always #5 clk = ~clk;

  osd_mam_burst_splitter #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_BURST(16), .BOUNDARY(4096)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw), .req_addr(req_addr),
    .req_burst(req_burst), .req_beats(req_beats),
    .write_valid(write_valid), .write_data(write_data), .write_strb(write_strb), .write_ready(write_ready),
    .read_valid(read_valid), .read_data(read_data), .read_ready(read_ready),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_burst(mem_req_burst), .mem_req_beats(mem_req_beats),
    .mem_write_valid(mem_write_valid), .mem_write_data(mem_write_data), .mem_write_strb(mem_write_strb),
    .mem_write_ready(mem_write_ready),
    .mem_read_valid(mem_read_valid), .mem_read_data(mem_read_data), .mem_read_ready(mem_read_ready),
    .busy(busy)
  );

  typedef struct {
    logic             rw;
    logic [31:0]      addr;
    logic             burst;
    logic [13:0]      beats;
    logic [3:0]       strb;
    int               n;
    logic [2:0][31:0] ea;
    logic [2:0][13:0] eb;
  } vec_t;

  vec_t vecs[7];

  function automatic vec_t mk(input logic rw, input logic [31:0] addr, input logic burst,
                              input logic [13:0] beats, input logic [3:0] strb, input int n,
                              input logic [31:0] a0, input logic [13:0] b0,
                              input logic [31:0] a1, input logic [13:0] b1,
                              input logic [31:0] a2, input logic [13:0] b2);
    vec_t v;
    v.rw = rw; v.addr = addr; v.burst = burst; v.beats = beats; v.strb = strb; v.n = n;
    v.ea[0] = a0; v.eb[0] = b0;
    v.ea[1] = a1; v.eb[1] = b1;
    v.ea[2] = a2; v.eb[2] = b2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string name);
    chk(name, {25'd0, mem_req_valid, busy, req_ready, write_ready, mem_write_valid,
               read_valid, mem_read_ready}, 32'd0);
  endtask

  // Wait for one sub-request, check it (holding ready low for `stall` cycles), then move its beats.
  task automatic serve_chunk(input logic rw, input logic [31:0] ea, input logic [13:0] eb,
                             input logic eburst, input logic [3:0] strb, input int stall);
    int waited = 0;
    logic [31:0] data;
    while (!mem_req_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("issue_delay", waited, 0);
    if (!mem_req_valid) return;
    for (int s = 0; s <= stall; s++) begin
      write_valid = 1'b1; mem_write_ready = 1'b1; mem_read_valid = 1'b1; read_ready = 1'b1;
      #1;
      chk("issue_valid", {31'd0, mem_req_valid}, 32'd1);
      chk("issue_addr", mem_req_addr, ea);
      chk("issue_beats", {18'd0, mem_req_beats}, {18'd0, eb});
      chk("issue_burst_rw", {30'd0, mem_req_burst, mem_req_rw}, {30'd0, eburst, rw});
      chk("issue_req_ready", {31'd0, req_ready}, 32'd0);
      chk("issue_data_gated", {28'd0, mem_write_valid, write_ready, read_valid, mem_read_ready}, 32'd0);
      if (s < stall) @(negedge clk);
    end
    write_valid = 1'b0; mem_write_ready = 1'b0; mem_read_valid = 1'b0; read_ready = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    for (int b = 0; b < int'(eb); b++) begin
      data = 32'hA500_0000 + 32'(beat_seq);
      if (rw) begin
        write_valid = 1'b1; write_data = data; write_strb = strb; mem_write_ready = 1'b1;
        #1;
        chk("wr_handshake", {30'd0, mem_write_valid, write_ready}, 32'd3);
        chk("wr_data", mem_write_data, data);
        chk("wr_strb", {28'd0, mem_write_strb}, {28'd0, strb});
      end else begin
        mem_read_valid = 1'b1; mem_read_data = data; read_ready = 1'b1;
        #1;
        chk("rd_handshake", {30'd0, read_valid, mem_read_ready}, 32'd3);
        chk("rd_data", read_data, data);
      end
      beat_seq++;
      @(negedge clk);
    end
    write_valid = 1'b0; mem_write_ready = 1'b0; mem_read_valid = 1'b0; read_ready = 1'b0;
  endtask

  task automatic send_req(input logic rw, input logic [31:0] addr, input logic burst, input logic [13:0] beats);
    chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_rw = rw; req_addr = addr; req_burst = burst; req_beats = beats;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic chk_done(input string name);
    chk(name, {29'd0, busy, req_ready, mem_req_valid}, 32'b010);
  endtask

  task automatic run_vec(input vec_t v);
    send_req(v.rw, v.addr, v.burst, v.beats);
    for (int i = 0; i < v.n; i++)
      serve_chunk(v.rw, v.ea[i], v.eb[i], v.burst, v.strb, 0);
    chk_done("vec_done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(1'b0, 32'h0000_0000, 1'b1, 14'd40, 4'hF, 3, 32'h000, 14'd16, 32'h040, 14'd16, 32'h080, 14'd8);
    vecs[1] = mk(1'b1, 32'h0000_0FF8, 1'b1, 14'd10, 4'hF, 2, 32'hFF8, 14'd2, 32'h1000, 14'd8, 32'h0, 14'd0);
    vecs[2] = mk(1'b1, 32'h0000_1234, 1'b0, 14'd7,  4'b0011, 1, 32'h1234, 14'd1, 32'h0, 14'd0, 32'h0, 14'd0);
    vecs[3] = mk(1'b0, 32'h0000_0FFE, 1'b1, 14'd3,  4'hF, 2, 32'hFFC, 14'd1, 32'h1000, 14'd2, 32'h0, 14'd0);
    vecs[4] = mk(1'b0, 32'hFFFF_FFF8, 1'b1, 14'd4,  4'hF, 2, 32'hFFFF_FFF8, 14'd2, 32'h0, 14'd2, 32'h0, 14'd0);
    vecs[5] = mk(1'b1, 32'h0000_0100, 1'b1, 14'd16, 4'hA, 1, 32'h100, 14'd16, 32'h0, 14'd0, 32'h0, 14'd0);
    vecs[6] = mk(1'b1, 32'h0000_0FC0, 1'b1, 14'd20, 4'h5, 2, 32'hFC0, 14'd16, 32'h1000, 14'd4, 32'h0, 14'd0);

    rst_n = 1'b0;
    req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_burst = 1'b0; req_beats = '0;
    write_valid = 1'b0; write_data = '0; write_strb = '0; read_ready = 1'b0;
    mem_req_ready = 1'b0; mem_write_ready = 1'b0; mem_read_valid = 1'b0; mem_read_data = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset_outputs");
    chk("reset_addr", mem_req_addr, 32'd0);
    chk("reset_beats", {18'd0, mem_req_beats}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("release_req_ready", {30'd0, req_ready, busy}, 32'b10);
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Zero-length burst is swallowed.
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 32'h40; req_burst = 1'b1; req_beats = 14'd0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk_done("zero_beats_idle");
      @(negedge clk);
    end

    // Downstream stalls the request for 5 cycles.
    send_req(1'b0, 32'h0000_0200, 1'b1, 14'd2);
    serve_chunk(1'b0, 32'h200, 14'd2, 1'b1, 4'hF, 5);
    chk_done("stall_done");

    // Reset during beat 3 of a 16-beat read, then immediate new request.
    send_req(1'b0, 32'h0000_0000, 1'b1, 14'd16);
    chk("mid_issue", {31'd0, mem_req_valid}, 32'd1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_read_valid = 1'b1; read_ready = 1'b1; mem_read_data = 32'h0BEE_0000 + 32'(b);
      #1;
      chk("mid_rd_data", read_data, 32'h0BEE_0000 + 32'(b));
      @(negedge clk);
    end
    mem_read_valid = 1'b1; read_ready = 1'b1; write_valid = 1'b1; mem_write_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("mid_reset_outputs");
    chk("mid_reset_addr", mem_req_addr, 32'd0);
    @(negedge clk);
    mem_read_valid = 1'b0; read_ready = 1'b0; write_valid = 1'b0; mem_write_ready = 1'b0;
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 32'h80; req_burst = 1'b0; req_beats = 14'd1;
    rst_n = 1'b1;
    #1;
    chk("post_reset_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("post_reset_accepted", {31'd0, busy}, 32'd1);
    serve_chunk(1'b1, 32'h80, 14'd1, 1'b0, 4'b0110, 0);
    chk_done("post_reset_done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
